// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions used by the fetch stage: fetch FSM encoding,
// bubble instruction and default reset vector.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline register: bubble beats load, otherwise load or hold.
module ifid_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_load,
    input  logic        in_bubble,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_instr,
    output logic        out_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic [31:0] r_instr;
    logic        r_valid;

    // A bubble keeps the PC fields; only the instruction and valid flag change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (in_bubble) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (in_load) begin
            r_pc    <= in_pc;
            r_pc4   <= pc_plus4(in_pc);
            r_instr <= in_instr;
            r_valid <= 1'b1;
        end
    end

    assign out_pc    = r_pc;
    assign out_pc4   = r_pc4;
    assign out_instr = r_instr;
    assign out_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, memory request handshake,
// stall buffering and flush draining in front of the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_pcwrite,
    input  logic        in_ifidwrite,
    input  logic        in_flush,
    input  logic [31:0] in_branch_target,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ready,
    input  logic [31:0] in_imem_rdata,
    output logic [31:0] out_ifid_pc,
    output logic [31:0] out_ifid_pc4,
    output logic [31:0] out_ifid_instr,
    output logic        out_ifid_valid,
    output logic [4:0]  out_ifid_rs1,
    output logic [4:0]  out_ifid_rs2
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_addr;
    logic [31:0]  w_addr_next;
    logic [31:0]  r_buf;
    logic [31:0]  w_buf_next;
    logic         w_ifid_load;
    logic         w_ifid_bubble;
    logic [31:0]  w_ifid_instr_in;
    logic [31:0]  w_pc_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_buf   <= w_buf_next;
        end
    end

    assign w_pc_adv = in_pcwrite ? pc_plus4(r_pc) : r_pc;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_addr_next     = r_addr;
        w_buf_next      = r_buf;
        w_ifid_load     = 1'b0;
        w_ifid_bubble   = 1'b0;
        w_ifid_instr_in = in_imem_rdata;

        if (in_flush) begin
            w_ifid_bubble = 1'b1;
            w_pc_next     = in_branch_target;
            // Only an outstanding, unanswered request forces a trip through DRAIN.
            if (r_state == ST_HOLD || in_imem_ready) begin
                w_state_next = ST_FETCH;
                w_addr_next  = in_branch_target;
            end else begin
                w_state_next = ST_DRAIN;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (in_imem_ready) begin
                        if (in_ifidwrite) begin
                            w_ifid_load = 1'b1;
                            w_pc_next   = w_pc_adv;
                            w_addr_next = w_pc_adv;
                        end else begin
                            w_buf_next   = in_imem_rdata;
                            w_state_next = ST_HOLD;
                        end
                    end else if (in_ifidwrite) begin
                        w_ifid_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_ifid_instr_in = r_buf;
                    if (in_ifidwrite) begin
                        w_ifid_load  = 1'b1;
                        w_pc_next    = w_pc_adv;
                        w_addr_next  = w_pc_adv;
                        w_state_next = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    w_ifid_bubble = in_ifidwrite;
                    if (in_imem_ready) begin
                        w_addr_next  = r_pc;
                        w_state_next = ST_FETCH;
                    end
                end
                default: begin
                    w_state_next = ST_FETCH;
                    w_addr_next  = r_pc;
                end
            endcase
        end
    end

    assign out_imem_req  = (r_state != ST_HOLD);
    assign out_imem_addr = r_addr;

    ifid_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_load   (w_ifid_load),
        .in_bubble (w_ifid_bubble),
        .in_pc     (r_addr),
        .in_instr  (w_ifid_instr_in),
        .out_pc    (out_ifid_pc),
        .out_pc4   (out_ifid_pc4),
        .out_instr (out_ifid_instr),
        .out_valid (out_ifid_valid)
    );

    assign out_ifid_rs1 = out_ifid_instr[19:15];
    assign out_ifid_rs2 = out_ifid_instr[24:20];

endmodule
